// File: rtl/read_sched.sv
// Round-robin scheduler granting one of two requesters a BEATS-cycle row read.
// All outputs are flops updated alongside the state register (Moore).
module read_sched #(
    parameter int BEATS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [4:0] addr_a,
    input  logic       req_b,
    input  logic [4:0] addr_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic       read_en,
    output logic [4:0] in_addr,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] beat;
    logic       owner_b;
    logic       last_b;
    logic       pick_b;

    // B wins when alone, or when both ask and A was served last.
    assign pick_b = req_b && !(req_a && last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= '0;
            owner_b <= 1'b0;
            last_b  <= 1'b1;
            in_addr <= '0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            read_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            read_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        owner_b <= pick_b;
                        in_addr <= pick_b ? addr_b : addr_a;
                        gnt_a   <= !pick_b;
                        gnt_b   <= pick_b;
                        read_en <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    beat  <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    beat <= beat + 6'd1;
                    if (beat == 6'(BEATS - 1)) begin
                        done_a <= !owner_b;
                        done_b <= owner_b;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    last_b <= owner_b;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_sched.sv
// Bench for read_sched: directed vector table, corner sequences, and a
// randomized run checked against a timestamp-based transaction model.
module tb_read_sched;
    localparam int BEATS = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [4:0] addr_a = '0, addr_b = '0;
    logic       gnt_a, gnt_b, done_a, done_b, read_en, busy;
    logic [4:0] in_addr;
    logic [10:0] obs;

    read_sched #(.BEATS(BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a), .req_b(req_b), .addr_b(addr_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .read_en(read_en), .in_addr(in_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {gnt_a, gnt_b, done_a, done_b, read_en, busy, in_addr};

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [10:0] mk(input logic ga, input logic gb, input logic da,
                                       input logic db, input logic re, input logic bz,
                                       input logic [4:0] ad);
        return {ga, gb, da, db, re, bz, ad};
    endfunction

    task automatic chk_o(input string nm, input logic [10:0] act, input logic [10:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ga,gb,da,db,re,busy,addr}=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Protocol monitor: mutual exclusion and strict gnt/done pairing.
    int pend = 0;  // 0 none, 1 A outstanding, 2 B outstanding
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            n_tests++;
            if ((gnt_a && gnt_b) || (done_a && done_b) ||
                ((gnt_a || gnt_b) && (done_a || done_b))) begin
                n_fail++;
                $display("FAIL exclusivity: gnt=%b%b done=%b%b", gnt_a, gnt_b, done_a, done_b);
            end
            if (gnt_a || gnt_b) begin
                if (pend != 0) begin
                    n_fail++;
                    $display("FAIL pairing: grant while %0d outstanding, required none", pend);
                end
                pend = gnt_a ? 1 : 2;
            end
            if (done_a || done_b) begin
                if (pend != (done_a ? 1 : 2)) begin
                    n_fail++;
                    $display("FAIL pairing: done_%s with outstanding %0d", done_a ? "a" : "b", pend);
                end
                pend = 0;
            end
        end
    end

    // Transaction model: a launch at cycle L owns the reader through L+BEATS+1.
    int         cyc, launch_c, free_c;
    logic       m_own_b, m_last_b;
    logic [4:0] m_addr;

    function automatic logic [10:0] m_exp(input int m);
        logic act = (m == launch_c);
        logic dn  = (m == launch_c + BEATS + 1);
        logic bz  = (m >= launch_c) && (m <= launch_c + BEATS + 1);
        return mk(act && !m_own_b, act && m_own_b, dn && !m_own_b, dn && m_own_b, act, bz, m_addr);
    endfunction

    task automatic m_reset();
        launch_c = -1000;
        free_c   = cyc + 1;
        m_last_b = 1'b1;
        m_own_b  = 1'b0;
        m_addr   = '0;
    endtask

    task automatic m_step();
        if (!rst_n) begin
            m_reset();
        end else if (cyc >= free_c && (req_a || req_b)) begin
            m_own_b  = req_b && !(req_a && m_last_b);
            m_last_b = m_own_b;
            m_addr   = m_own_b ? addr_b : addr_a;
            launch_c = cyc + 1;
            free_c   = cyc + BEATS + 3;
        end
    endtask

    typedef struct {
        logic       ra, rb;
        logic [4:0] aa, ab;
        logic       wb;   // expected winner is B
        logic [4:0] ea;   // expected in_addr
    } vec_t;
    vec_t tbl[8];

    task automatic run_row(input vec_t v, input int idx);
        req_a = v.ra; req_b = v.rb; addr_a = v.aa; addr_b = v.ab;
        @(negedge clk);
        chk_o($sformatf("row%0d grant", idx), obs, mk(!v.wb, v.wb, 1'b0, 1'b0, 1'b1, 1'b1, v.ea));
        req_a = 1'b0; req_b = 1'b0; addr_a = ~v.aa; addr_b = ~v.ab;
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            chk_o($sformatf("row%0d busy%0d", idx, k), obs, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v.ea));
        end
        @(negedge clk);
        chk_o($sformatf("row%0d done", idx), obs, mk(1'b0, 1'b0, !v.wb, v.wb, 1'b0, 1'b1, v.ea));
        @(negedge clk);
        chk_o($sformatf("row%0d idle", idx), obs, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v.ea));
    endtask

    int         g_cyc[$];
    logic       g_b[$];
    logic [4:0] g_ad[$];
    int         e_cyc[3] = '{1, 36, 71};
    logic       e_b[3]   = '{1'b0, 1'b1, 1'b0};
    int         rst_hold = 0;

    initial begin
        tbl[0] = '{ra: 1'b1, rb: 1'b0, aa: 5'h0A, ab: 5'h00, wb: 1'b0, ea: 5'h0A};
        tbl[1] = '{ra: 1'b1, rb: 1'b1, aa: 5'h03, ab: 5'h1C, wb: 1'b1, ea: 5'h1C};
        tbl[2] = '{ra: 1'b1, rb: 1'b1, aa: 5'h11, ab: 5'h02, wb: 1'b0, ea: 5'h11};
        tbl[3] = '{ra: 1'b0, rb: 1'b1, aa: 5'h05, ab: 5'h1F, wb: 1'b1, ea: 5'h1F};
        tbl[4] = '{ra: 1'b0, rb: 1'b1, aa: 5'h06, ab: 5'h00, wb: 1'b1, ea: 5'h00};
        tbl[5] = '{ra: 1'b1, rb: 1'b1, aa: 5'h15, ab: 5'h0A, wb: 1'b0, ea: 5'h15};
        tbl[6] = '{ra: 1'b1, rb: 1'b0, aa: 5'h07, ab: 5'h12, wb: 1'b0, ea: 5'h07};
        tbl[7] = '{ra: 1'b1, rb: 1'b1, aa: 5'h01, ab: 5'h1E, wb: 1'b1, ea: 5'h1E};

        // Reset state
        @(negedge clk);
        req_a = 1'b1; req_b = 1'b1; addr_a = 5'h1F; addr_b = 5'h1F;
        @(negedge clk);
        chk_o("reset state", obs, 11'd0);
        req_a = 1'b0; req_b = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_row(tbl[i], i);

        // Mid-row reset aborts silently, then a clean relaunch
        req_a = 1'b1; addr_a = 5'h0A;
        @(negedge clk);
        chk_o("abort grant", obs, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0A));
        req_a = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_o("abort immediate", obs, 11'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_o($sformatf("abort hold%0d", k), obs, 11'd0);
        end
        rst_n = 1'b1; req_a = 1'b1; addr_a = 5'h13;
        @(negedge clk);
        chk_o("relaunch grant", obs, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h13));
        req_a = 1'b0;
        repeat (BEATS) @(negedge clk);
        @(negedge clk);
        chk_o("relaunch done", obs, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'h13));
        @(negedge clk);

        // Both held from reset: strict A,B,A alternation
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1; addr_a = 5'h04; addr_b = 5'h19;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin
                g_cyc.push_back(c); g_b.push_back(gnt_b); g_ad.push_back(in_addr);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk_i("alt grant count", g_cyc.size(), 3);
        for (int k = 0; k < 3 && k < g_cyc.size(); k++) begin
            chk_i($sformatf("alt%0d cycle", k), g_cyc[k], e_cyc[k]);
            chk_i($sformatf("alt%0d owner_b", k), int'(g_b[k]), int'(e_b[k]));
            chk_i($sformatf("alt%0d addr", k), int'(g_ad[k]), e_b[k] ? 32'h19 : 32'h04);
        end
        repeat (BEATS + 3) @(negedge clk);

        // Randomized run against the transaction model
        @(negedge clk);
        rst_n = 1'b0;
        cyc = 0;
        m_reset();
        m_step();
        cyc = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            chk_o($sformatf("model cyc%0d", cyc), obs, m_exp(cyc));
            if (rst_hold > 0) begin
                rst_hold--;
                rst_n = 1'b0;
            end else if (i > 4 && $urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                rst_hold = $urandom_range(0, 2);
            end else begin
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) req_a = ~req_a;
            if ($urandom_range(0, 7) == 0) req_b = ~req_b;
            if ($urandom_range(0, 3) == 0) addr_a = 5'($urandom);
            if ($urandom_range(0, 3) == 0) addr_b = 5'($urandom);
            m_step();
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
